apb_master_arbiter: RTL and testbench



---
 rtl/apb_master_arbiter.sv | 246 ++++++++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// apb_master_arbiter
//
// Purpose:
//   Shares one APB master port between two requesters.
//   - Requester 0 is the host/config path.
//   - Requester 1 is the DMA/operand loader.
//   One transfer is in flight at a time. The arbiter drives the SETUP and
//   ACCESS phases, waits for pready_i, and hands read data and the error flag
//   back to the requester that was granted.
//
// Arbitration:
//   - A lone valid requester wins.
//   - When both are valid, the one that was not granted last wins.
//   - After reset last_grant is 1, so requester 0 wins the first contention.
//
// Optional feature (macro APB_ARB_TIMEOUT_EN):
//   An ACCESS-phase watchdog. After TIMEOUT_CYCLES ACCESS cycles without
//   pready_i, the transfer is abandoned and completes with err = 1 and
//   rdata = 0. Without the macro, ACCESS waits for pready_i forever.
//
// Ports:
//   clk_i, rst_i         clock (rising edge), synchronous active-high reset
//   reqN_valid_i         requester N has a transfer pending (N = 0, 1)
//   reqN_write_i         1 = write, 0 = read
//   reqN_addr_i          transfer address
//   reqN_wdata_i         write data
//   reqN_strb_i          write strobes
//   reqN_ready_o         request accepted this cycle (combinational)
//   reqN_done_o          one-cycle completion pulse
//   reqN_rdata_o         read data; valid with done, held until the next done
//   reqN_err_o           error flag; valid with done, held until the next done
//   psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o
//                        APB request signals
//   pready_i, prdata_i, pslverr_i
//                        APB response signals
//   busy_o               a transfer is in flight
// -----------------------------------------------------------------------------
module apb_master_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int BUS_WIDTH      = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int MAX_DIM       = BUS_WIDTH / DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req0_valid_i,
  input  logic                  req0_write_i,
  input  logic [ADDR_WIDTH-1:0] req0_addr_i,
  input  logic [BUS_WIDTH-1:0]  req0_wdata_i,
  input  logic [MAX_DIM-1:0]    req0_strb_i,
  output logic                  req0_ready_o,
  output logic                  req0_done_o,
  output logic [BUS_WIDTH-1:0]  req0_rdata_o,
  output logic                  req0_err_o,
  input  logic                  req1_valid_i,
  input  logic                  req1_write_i,
  input  logic [ADDR_WIDTH-1:0] req1_addr_i,
  input  logic [BUS_WIDTH-1:0]  req1_wdata_i,
  input  logic [MAX_DIM-1:0]    req1_strb_i,
  output logic                  req1_ready_o,
  output logic                  req1_done_o,
  output logic [BUS_WIDTH-1:0]  req1_rdata_o,
  output logic                  req1_err_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [BUS_WIDTH-1:0]  pwdata_o,
  output logic [MAX_DIM-1:0]    pstrb_o,
  input  logic                  pready_i,
  input  logic [BUS_WIDTH-1:0]  prdata_i,
  input  logic                  pslverr_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;  // also the owner of the in-flight transfer
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [BUS_WIDTH-1:0]  pwdata_q, pwdata_d;
  logic [MAX_DIM-1:0]    pstrb_q, pstrb_d;
  logic                  done0_q, done0_d, done1_q, done1_d;
  logic                  err0_q, err0_d, err1_q, err1_d;
  logic [BUS_WIDTH-1:0]  rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic                  winner;
  logic                  complete;
  logic                  cpl_err;
  logic [BUS_WIDTH-1:0]  cpl_rdata;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  // Alternate on contention, otherwise grant whoever is asking.
  always_comb begin
    if (req0_valid_i && req1_valid_i) begin
      winner = ~last_grant_q;
    end else begin
      winner = req1_valid_i;
    end
  end

  // Ready is gated by reset so that an acceptance is never signalled in a
  // cycle whose state update will be discarded.
  assign req0_ready_o = (state_q == IDLE) && !rst_i && req0_valid_i && !winner;
  assign req1_ready_o = (state_q == IDLE) && !rst_i && req1_valid_i &&  winner;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    err0_d       = err0_q;
    err1_d       = err1_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    complete     = 1'b0;
    cpl_err      = 1'b0;
    cpl_rdata    = '0;
`ifdef APB_ARB_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (req0_valid_i || req1_valid_i) begin
          state_d      = SETUP;
          last_grant_d = winner;
          pwrite_d     = winner ? req1_write_i : req0_write_i;
          paddr_d      = winner ? req1_addr_i  : req0_addr_i;
          // Reads never put data or strobes on the bus.
          if (winner ? req1_write_i : req0_write_i) begin
            pwdata_d = winner ? req1_wdata_i : req0_wdata_i;
            pstrb_d  = winner ? req1_strb_i  : req0_strb_i;
          end else begin
            pwdata_d = '0;
            pstrb_d  = '0;
          end
`ifdef APB_ARB_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready_i) begin
          complete  = 1'b1;
          cpl_err   = pslverr_i;
          cpl_rdata = pwrite_q ? '0 : prdata_i;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Last allowed ACCESS cycle without pready: abandon the transfer.
          complete  = 1'b1;
          cpl_err   = 1'b1;
          cpl_rdata = '0;
        end else begin
          to_cnt_d = to_cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (complete) begin
      state_d = IDLE;
      if (last_grant_q) begin
        done1_d  = 1'b1;
        err1_d   = cpl_err;
        rdata1_d = cpl_rdata;
      end else begin
        done0_d  = 1'b1;
        err0_d   = cpl_err;
        rdata0_d = cpl_rdata;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
`ifdef APB_ARB_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
`endif
    end
  end

  assign psel_o       = (state_q != IDLE);
  assign penable_o    = (state_q == ACCESS);
  assign busy_o       = (state_q != IDLE);
  assign pwrite_o     = pwrite_q;
  assign paddr_o      = paddr_q;
  assign pwdata_o     = pwdata_q;
  assign pstrb_o      = pstrb_q;
  assign req0_done_o  = done0_q;
  assign req1_done_o  = done1_q;
  assign req0_err_o   = err0_q;
  assign req1_err_o   = err1_q;
  assign req0_rdata_o = rdata0_q;
  assign req1_rdata_o = rdata1_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_master_arbiter
//
// Directed scenarios with literal expectations, followed by a randomized run.
// A transaction-level model (one in-flight record plus per-requester result
// registers) predicts every DUT output on every cycle.
// -----------------------------------------------------------------------------
module tb_apb_master_arbiter;

  localparam int DW = 32;
  localparam int BW = 64;
  localparam int AW = 32;
  localparam int TO = 16;
  localparam int SW = BW / DW;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          req0_valid_i = 1'b0, req0_write_i = 1'b0;
  logic [AW-1:0] req0_addr_i = '0;
  logic [BW-1:0] req0_wdata_i = '0;
  logic [SW-1:0] req0_strb_i = '0;
  logic          req1_valid_i = 1'b0, req1_write_i = 1'b0;
  logic [AW-1:0] req1_addr_i = '0;
  logic [BW-1:0] req1_wdata_i = '0;
  logic [SW-1:0] req1_strb_i = '0;
  logic          req0_ready_o, req0_done_o, req0_err_o;
  logic [BW-1:0] req0_rdata_o;
  logic          req1_ready_o, req1_done_o, req1_err_o;
  logic [BW-1:0] req1_rdata_o;
  logic          psel_o, penable_o, pwrite_o, busy_o;
  logic [AW-1:0] paddr_o;
  logic [BW-1:0] pwdata_o;
  logic [SW-1:0] pstrb_o;
  logic          pready_i = 1'b0;
  logic [BW-1:0] prdata_i = '0;
  logic          pslverr_i = 1'b0;

  int total = 0;
  int bad = 0;

  apb_master_arbiter #(
    .DATA_WIDTH(DW), .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_write_i(req0_write_i), .req0_addr_i(req0_addr_i),
    .req0_wdata_i(req0_wdata_i), .req0_strb_i(req0_strb_i), .req0_ready_o(req0_ready_o),
    .req0_done_o(req0_done_o), .req0_rdata_o(req0_rdata_o), .req0_err_o(req0_err_o),
    .req1_valid_i(req1_valid_i), .req1_write_i(req1_write_i), .req1_addr_i(req1_addr_i),
    .req1_wdata_i(req1_wdata_i), .req1_strb_i(req1_strb_i), .req1_ready_o(req1_ready_o),
    .req1_done_o(req1_done_o), .req1_rdata_o(req1_rdata_o), .req1_err_o(req1_err_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
    .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .pready_i(pready_i), .prdata_i(prdata_i),
    .pslverr_i(pslverr_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: one transfer record, the cycles elapsed since it was
  // accepted, and per-requester result registers.
  // ---------------------------------------------------------------------------
  bit            m_on = 0;
  bit            m_busy = 0;
  int            m_age = 0;      // 1 = select-only cycle, >= 2 = enable cycles
  bit            m_owner = 0;
  bit            m_last = 1;
  bit            m_wr = 0;
  logic [AW-1:0] m_addr = '0;
  logic [BW-1:0] m_wdata = '0;
  logic [SW-1:0] m_strb = '0;
  bit            m_done [2];
  logic [BW-1:0] m_rdata [2];
  bit            m_err [2];
  bit            m_acc0 = 0, m_acc1 = 0;
  bit            e_r0, e_r1;

  task automatic model_finish(input logic [BW-1:0] rd, input bit er);
    m_done[m_owner]  = 1'b1;
    m_rdata[m_owner] = rd;
    m_err[m_owner]   = er;
    m_busy           = 1'b0;
    $display("xfer req%0d %s addr=%h rdata=%h err=%0d t=%0t", m_owner,
             m_wr ? "WR" : "RD", m_addr, rd, er, $time);
  endtask

  always @(negedge clk_i) begin
    e_r0 = !rst_i && !m_busy && req0_valid_i && (!req1_valid_i || m_last);
    e_r1 = !rst_i && !m_busy && req1_valid_i && (!req0_valid_i || !m_last);
    if (m_on) begin
      chk("ready0", req0_ready_o, e_r0);
      chk("ready1", req1_ready_o, e_r1);
      chk("busy", busy_o, m_busy);
      chk("psel", psel_o, m_busy);
      chk("penable", penable_o, m_busy && m_age >= 2);
      chk("done0", req0_done_o, m_done[0]);
      chk("done1", req1_done_o, m_done[1]);
      chk("rdata0", req0_rdata_o, m_rdata[0]);
      chk("rdata1", req1_rdata_o, m_rdata[1]);
      chk("err0", req0_err_o, m_err[0]);
      chk("err1", req1_err_o, m_err[1]);
      if (m_busy) begin
        chk("pwrite", pwrite_o, m_wr);
        chk("paddr", paddr_o, m_addr);
        chk("pwdata", pwdata_o, m_wdata);
        chk("pstrb", pstrb_o, m_strb);
      end
    end
    // Advance the model across the coming edge.
    m_acc0 = e_r0;
    m_acc1 = e_r1;
    m_done[0] = 1'b0;
    m_done[1] = 1'b0;
    if (rst_i) begin
      m_on = 1;
      m_busy = 0;
      m_last = 1;
      m_rdata[0] = '0; m_rdata[1] = '0;
      m_err[0] = 0;    m_err[1] = 0;
    end else if (m_busy) begin
      if (m_age >= 2 && pready_i) begin
        model_finish(m_wr ? '0 : prdata_i, pslverr_i);
      end
`ifdef APB_ARB_TIMEOUT_EN
      else if (m_age == TO + 1) begin
        model_finish('0, 1'b1);
      end
`endif
      else begin
        m_age++;
      end
    end else if (e_r0 || e_r1) begin
      m_busy  = 1;
      m_age   = 1;
      m_owner = e_r1;
      m_last  = e_r1;
      m_wr    = e_r1 ? req1_write_i : req0_write_i;
      m_addr  = e_r1 ? req1_addr_i : req0_addr_i;
      m_wdata = m_wr ? (e_r1 ? req1_wdata_i : req0_wdata_i) : '0;
      m_strb  = m_wr ? (e_r1 ? req1_strb_i : req0_strb_i) : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk_i);
  endtask

  task automatic set_req(input bit r, input bit v, input bit wr, input logic [AW-1:0] a,
                         input logic [BW-1:0] wd, input logic [SW-1:0] s);
    if (r) begin
      req1_valid_i = v; req1_write_i = wr; req1_addr_i = a; req1_wdata_i = wd; req1_strb_i = s;
    end else begin
      req0_valid_i = v; req0_write_i = wr; req0_addr_i = a; req0_wdata_i = wd; req0_strb_i = s;
    end
  endtask

  // Single uncontended transfer; the slave answers after k wait cycles in ACCESS.
  task automatic do_xfer(input bit r, input bit wr, input logic [AW-1:0] a,
                         input logic [BW-1:0] wd, input logic [SW-1:0] s, input int k,
                         input logic [BW-1:0] prd, input bit serr);
    set_req(r, 1'b1, wr, a, wd, s);
    pready_i = 1'b0;
    at_neg();
    chk("x_ready_win", r ? req1_ready_o : req0_ready_o, 1'b1);
    chk("x_ready_other", r ? req0_ready_o : req1_ready_o, 1'b0);
    cyc();
    set_req(r, 1'b0, wr, a, wd, s);
    at_neg();
    chk("x_setup_psel", psel_o, 1'b1);
    chk("x_setup_penable", penable_o, 1'b0);
    chk("x_pstrb", pstrb_o, wr ? s : '0);
    chk("x_pwdata", pwdata_o, wr ? wd : '0);
    cyc();
    for (int i = 0; i < k; i++) begin
      pslverr_i = 1'b1;                     // must be ignored without pready
      at_neg();
      chk("x_access_penable", penable_o, 1'b1);
      cyc();
    end
    pready_i = 1'b1; prdata_i = prd; pslverr_i = serr;
    at_neg();
    chk("x_access_penable", penable_o, 1'b1);
    cyc();
    pready_i = 1'b0; pslverr_i = 1'b0;
    at_neg();
    chk("x_done", r ? req1_done_o : req0_done_o, 1'b1);
    chk("x_err", r ? req1_err_o : req0_err_o, serr);
    chk("x_rdata", r ? req1_rdata_o : req0_rdata_o, wr ? '0 : prd);
    chk("x_psel_drop", psel_o, 1'b0);
    cyc();
  endtask

  bit p0, p1;
  int got;

  initial begin
    // Reset state
    rst_i = 1'b1;
    repeat (3) cyc();
    at_neg();
    chk("rst_psel", psel_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_paddr", paddr_o, '0);
    chk("rst_pwdata", pwdata_o, '0);
    chk("rst_pstrb", pstrb_o, '0);
    chk("rst_rdata0", req0_rdata_o, '0);
    chk("rst_err1", req1_err_o, 1'b0);
    chk("rst_done0", req0_done_o, 1'b0);
    cyc();
    rst_i = 1'b0;

    // Write from req0, pready one cycle into ACCESS: done at t+4
    do_xfer(1'b0, 1'b1, 32'h0, 64'h0000_0002_0000_0001, 2'b11, 1, 64'h0, 1'b0);
    // Read from req1: strobes/data suppressed on the bus
    do_xfer(1'b1, 1'b0, 32'h4, 64'h1234_5678_9ABC_DEF0, 2'b11, 0, 64'hDEAD_BEEF_0000_0001, 1'b0);
    // Slave error then a good write
    do_xfer(1'b0, 1'b1, 32'd12, 64'h55, 2'b01, 2, 64'hFFFF, 1'b1);
    do_xfer(1'b0, 1'b1, 32'd16, 64'h66, 2'b00, 0, 64'hFFFF, 1'b0);

    // Continuous contention after reset: order 0,1,0,1
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    set_req(1'b0, 1'b1, 1'b1, 32'h20, 64'hA0, 2'b11);
    set_req(1'b1, 1'b1, 1'b0, 32'h24, 64'hB0, 2'b10);
    pready_i = 1'b1;
    prdata_i = 64'h0BAD_F00D_0000_0002;
    got = 0;
    for (int i = 0; i < 60 && got < 4; i++) begin
      at_neg();
      chk("one_ready", req0_ready_o & req1_ready_o, 1'b0);
      if (req0_ready_o || req1_ready_o) begin
        chk("grant_order", req1_ready_o, got % 2);
        got++;
      end
      cyc();
      if (got == 4) begin
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
      end
    end
    chk("grant_count", got, 4);
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    repeat (5) cyc();
    pready_i = 1'b0;

    // Reset during ACCESS
    set_req(1'b1, 1'b1, 1'b0, 32'h8, 64'h0, 2'b11);
    cyc();
    set_req(1'b1, 1'b0, 1'b0, 32'h8, 64'h0, 2'b11);
    cyc();
    rst_i = 1'b1;
    at_neg();
    chk("pre_rst_penable", penable_o, 1'b1);
    cyc();
    rst_i = 1'b0;
    pready_i = 1'b1;
    at_neg();
    chk("rst_mid_psel", psel_o, 1'b0);
    chk("rst_mid_busy", busy_o, 1'b0);
    chk("rst_mid_done1", req1_done_o, 1'b0);
    cyc();
    set_req(1'b0, 1'b1, 1'b1, 32'h30, 64'h3, 2'b01);
    set_req(1'b1, 1'b1, 1'b1, 32'h34, 64'h4, 2'b10);
    at_neg();
    chk("rst_mid_nodone", req1_done_o, 1'b0);
    chk("post_rst_ready0", req0_ready_o, 1'b1);
    chk("post_rst_ready1", req1_ready_o, 1'b0);
    cyc();
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    repeat (5) cyc();
    pready_i = 1'b0;

    // Slave never ready
    set_req(1'b1, 1'b1, 1'b0, 32'h40, 64'h0, 2'b11);
    cyc();
    req1_valid_i = 1'b0;
    repeat (17) cyc();
    at_neg();
`ifdef APB_ARB_TIMEOUT_EN
    chk("to_done", req1_done_o, 1'b1);
    chk("to_err", req1_err_o, 1'b1);
    chk("to_rdata", req1_rdata_o, '0);
`else
    chk("stall_busy", busy_o, 1'b1);
    chk("stall_nodone", req1_done_o, 1'b0);
`endif
    cyc();
    pready_i = 1'b1;
    repeat (4) cyc();
    pready_i = 1'b0;

    // Randomized traffic
    p0 = 0;
    p1 = 0;
    for (int c = 0; c < 2000; c++) begin
      if (m_acc0) p0 = 0;
      if (m_acc1) p1 = 0;
      if (!p0) begin
        if ($urandom % 3 == 0) begin
          p0 = 1;
          set_req(1'b0, 1'b1, 1'($urandom), $urandom, {$urandom, $urandom}, 2'($urandom));
        end else begin
          req0_valid_i = 1'b0;
        end
      end else if ($urandom % 20 == 0) begin
        p0 = 0;
        req0_valid_i = 1'b0;
      end
      if (!p1) begin
        if ($urandom % 3 == 0) begin
          p1 = 1;
          set_req(1'b1, 1'b1, 1'($urandom), $urandom, {$urandom, $urandom}, 2'($urandom));
        end else begin
          req1_valid_i = 1'b0;
        end
      end else if ($urandom % 20 == 0) begin
        p1 = 0;
        req1_valid_i = 1'b0;
      end
      pready_i  = ($urandom % 2 == 0);
      prdata_i  = {$urandom, $urandom};
      pslverr_i = ($urandom % 4 == 0);
      rst_i     = ($urandom % 250 == 0);
      cyc();
    end
    rst_i = 1'b0;
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    pready_i = 1'b1;
    repeat (6) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
